// File: rtl/oam_read_arbiter.sv
// oam_read_arbiter: two-requester arbiter in front of a single OAM read port.
// Latency: grant is combinational with the request; read data returns on
// rvalidN exactly READ_LAT cycles after gntN. Backpressure: a losing or
// lock-stalled requester sees gnt=0 and must hold its request.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   req0/1, addr0/1     read request and OAM address per requester
//   lock0/1             keep ownership across consecutive reads
//   gnt0/1              read accepted this cycle (never both high)
//   rvalid0/1, rdata0/1 returned OAM word, one-cycle valid pulse per read
//   mem_addr, mem_rdata OAM read port (data captured READ_LAT-1 cycles
//                       after the address was driven)
//   busy                reads in flight or a lock held
//
// Optional feature: define OAM_ARB_ROUND_ROBIN_EN to replace fixed priority
// (requester 0 wins) with alternating priority on simultaneous requests.
module oam_read_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1    // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   g0, g1;

  logic [ADDR_W-1:0]   addr_q;
  logic [READ_LAT-1:0] pipe_v;   // read issued, one bit per latency stage
  logic [READ_LAT-1:0] pipe_id;  // requester of that read (1 = requester 1)
  logic                tap_v, tap_id;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

`ifdef OAM_ARB_ROUND_ROBIN_EN
  logic last_q;  // requester granted most recently
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant and next-state logic.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      LOCK0: begin
        if (req0 && lock0) begin
          g0 = 1'b1;
        end else begin
          // Owner released: the other side gets the port in the exit cycle.
          g1 = req1;
        end
      end
      LOCK1: begin
        if (req1 && lock1) begin
          g1 = 1'b1;
        end else begin
          g0 = req0;
        end
      end
      default: begin
        if (req0 && req1) begin
`ifdef OAM_ARB_ROUND_ROBIN_EN
          if (last_q) g0 = 1'b1;
          else        g1 = 1'b1;
`else
          g0 = 1'b1;
`endif
        end else begin
          g0 = req0;
          g1 = req1;
        end
      end
    endcase

    // Reset masks the grant even though it is combinational.
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end

    // Every state computes the same way: a locked grant owns the next cycle.
    if (g0 && lock0)      state_nxt = LOCK0;
    else if (g1 && lock1) state_nxt = LOCK1;
    else                  state_nxt = UNLOCKED;
  end

  assign gnt0     = g0;
  assign gnt1     = g1;
  assign mem_addr = g0 ? addr0 : (g1 ? addr1 : addr_q);

  // Memory data for a read is present READ_LAT-1 cycles after its grant, so
  // capture is keyed off the stage just ahead of the last one.
  generate
    if (READ_LAT == 1) begin : g_tap_direct
      assign tap_v  = g0 | g1;
      assign tap_id = g1;
    end else begin : g_tap_pipe
      assign tap_v  = pipe_v[READ_LAT-2];
      assign tap_id = pipe_id[READ_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      pipe_v   <= '0;
      pipe_id  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      addr_q     <= mem_addr;
      pipe_v[0]  <= g0 | g1;
      pipe_id[0] <= g1;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
      if (tap_v && !tap_id) rdata0_q <= mem_rdata;
      if (tap_v && tap_id)  rdata1_q <= mem_rdata;
    end
  end

`ifdef OAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (g0 || g1) begin
      last_q <= g1;
    end
  end
`endif

  assign rvalid0 = pipe_v[READ_LAT-1] & ~pipe_id[READ_LAT-1];
  assign rvalid1 = pipe_v[READ_LAT-1] &  pipe_id[READ_LAT-1];
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign busy    = (|pipe_v) | (state != UNLOCKED);

endmodule

// File: tb/tb_oam_read_arbiter.sv
// Bench for oam_read_arbiter: three instances (READ_LAT = 1, 2, 3) share the
// same request stimulus; each has its own OAM model whose data lags the
// address by READ_LAT-1 cycles. Accepted reads are queued with their due
// cycle and compared against the returned rvalid/rdata of each lane.
module tb_oam_read_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;

  logic          gnt0_w    [NL];
  logic          gnt1_w    [NL];
  logic          rvalid0_w [NL];
  logic          rvalid1_w [NL];
  logic [DW-1:0] rdata0_w  [NL];
  logic [DW-1:0] rdata1_w  [NL];
  logic [AW-1:0] mem_addr_w[NL];
  logic [DW-1:0] mem_rdata_w[NL];
  logic          busy_w    [NL];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int            due;
    int            lane;
    logic          id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] hold0[NL];
  logic [DW-1:0] hold1[NL];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 6'd5) return 32'hDEADBEEF;
    return {8'hC0, 2'b00, a, 8'h3C, 2'b00, ~a};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar k = 0; k < NL; k++) begin : g_lane
      logic [AW-1:0] dly0, dly1, rd_addr;
      always @(posedge clk) begin
        dly0 <= mem_addr_w[k];
        dly1 <= dly0;
      end
      if (k == 0)      begin : g_l1 assign rd_addr = mem_addr_w[k]; end
      else if (k == 1) begin : g_l2 assign rd_addr = dly0; end
      else             begin : g_l3 assign rd_addr = dly1; end
      assign mem_rdata_w[k] = mem_word(rd_addr);

      oam_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(k + 1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .lock0    (lock0),
        .lock1    (lock1),
        .gnt0     (gnt0_w[k]),
        .gnt1     (gnt1_w[k]),
        .rvalid0  (rvalid0_w[k]),
        .rvalid1  (rvalid1_w[k]),
        .rdata0   (rdata0_w[k]),
        .rdata1   (rdata1_w[k]),
        .mem_addr (mem_addr_w[k]),
        .mem_rdata(mem_rdata_w[k]),
        .busy     (busy_w[k])
      );
    end
  endgenerate

  // Scoreboard: compare returns due this cycle, then queue this cycle's grants.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      for (int k = 0; k < NL; k++) begin
        hold0[k] = '0;
        hold1[k] = '0;
      end
    end else begin
      for (int k = 0; k < NL; k++) begin
        logic ev0, ev1;
        ev0 = 1'b0;
        ev1 = 1'b0;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
          if (sbq[i].due == cyc && sbq[i].lane == k) begin
            if (sbq[i].id) begin ev1 = 1'b1; hold1[k] = sbq[i].data; end
            else           begin ev0 = 1'b1; hold0[k] = sbq[i].data; end
            sbq.delete(i);
          end
        end
        n_tests++;
        if (rvalid0_w[k] !== ev0 || rvalid1_w[k] !== ev1 ||
            rdata0_w[k] !== hold0[k] || rdata1_w[k] !== hold1[k]) begin
          n_fail++;
          $display("FAIL sb_return lane%0d cyc%0d: rvalid=%b%b rdata0=%h rdata1=%h, want rvalid=%b%b rdata0=%h rdata1=%h",
                   k, cyc, rvalid1_w[k], rvalid0_w[k], rdata0_w[k], rdata1_w[k],
                   ev1, ev0, hold0[k], hold1[k]);
        end
        n_tests++;
        if (gnt0_w[k] && gnt1_w[k]) begin
          n_fail++;
          $display("FAIL sb_exclusive lane%0d cyc%0d: gnt0=1 gnt1=1, want at most one", k, cyc);
        end
        if (gnt0_w[k] || gnt1_w[k]) begin
          logic [AW-1:0] a;
          exp_t e;
          a = gnt1_w[k] ? addr1 : addr0;
          n_tests++;
          if (mem_addr_w[k] !== a) begin
            n_fail++;
            $display("FAIL sb_mem_addr lane%0d cyc%0d: got %h want %h", k, cyc, mem_addr_w[k], a);
          end
          e.due  = cyc + k + 1;
          e.lane = k;
          e.id   = gnt1_w[k];
          e.data = mem_word(a);
          sbq.push_back(e);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    repeat (n) next_cycle();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1; addr0 = 6'd5; req1 = 1; addr1 = 6'd9;
    @(negedge clk);
    for (int k = 0; k < NL; k++) begin
      n_tests++;
      if (gnt0_w[k] !== 0 || gnt1_w[k] !== 0 || rvalid0_w[k] !== 0 || rvalid1_w[k] !== 0 ||
          rdata0_w[k] !== '0 || rdata1_w[k] !== '0 || mem_addr_w[k] !== '0 || busy_w[k] !== 0) begin
        n_fail++;
        $display("FAIL reset_state lane%0d: gnt=%b%b rv=%b%b rd0=%h rd1=%h ma=%h busy=%b, want all 0",
                 k, gnt1_w[k], gnt0_w[k], rvalid1_w[k], rvalid0_w[k], rdata0_w[k], rdata1_w[k],
                 mem_addr_w[k], busy_w[k]);
      end
    end
    next_cycle();
    reset_dut();
  endtask

  task automatic test_single_read();
    reset_dut();
    req0 = 1; addr0 = 6'h05; lock0 = 0;
    @(negedge clk);
    n_tests++;
    if (gnt0_w[0] !== 1 || gnt1_w[0] !== 0 || mem_addr_w[0] !== 6'h05) begin
      n_fail++;
      $display("FAIL single_grant: gnt0=%b gnt1=%b mem_addr=%h, want 1 0 05", gnt0_w[0], gnt1_w[0], mem_addr_w[0]);
    end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    n_tests++;
    if (rvalid0_w[0] !== 1 || rdata0_w[0] !== 32'hDEADBEEF || rvalid1_w[0] !== 0) begin
      n_fail++;
      $display("FAIL single_return: rvalid0=%b rdata0=%h rvalid1=%b, want 1 deadbeef 0",
               rvalid0_w[0], rdata0_w[0], rvalid1_w[0]);
    end
    next_cycle();
    idle(4);
  endtask

  task automatic test_arbitration();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      logic e1;
`ifdef OAM_ARB_ROUND_ROBIN_EN
      e1 = (i % 2 == 1);
`else
      e1 = 1'b0;
`endif
      req0 = 1; req1 = 1; addr0 = 6'(i); addr1 = 6'(16 + i);
      @(negedge clk);
      n_tests++;
      if (gnt0_w[0] !== ~e1 || gnt1_w[0] !== e1) begin
        n_fail++;
        $display("FAIL arb_order step%0d: gnt0=%b gnt1=%b, want %b %b", i, gnt0_w[0], gnt1_w[0], ~e1, e1);
      end
      next_cycle();
    end
    idle(5);
  endtask

  task automatic test_lock();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      logic e0, e1;
      req0 = (i != 0); addr0 = 6'd12;
      req1 = (i < 3);  lock1 = (i < 3); addr1 = 6'(20 + i);
      e1 = (i < 3);
      e0 = (i == 3);
      @(negedge clk);
      n_tests++;
      if (gnt0_w[0] !== e0 || gnt1_w[0] !== e1) begin
        n_fail++;
        $display("FAIL lock_hold step%0d: gnt0=%b gnt1=%b, want %b %b", i, gnt0_w[0], gnt1_w[0], e0, e1);
      end
      if (i == 1) begin
        n_tests++;
        if (busy_w[2] !== 1) begin
          n_fail++;
          $display("FAIL lock_busy: busy=%b, want 1", busy_w[2]);
        end
      end
      next_cycle();
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      req0 = (i != 1); addr0 = 6'(7 + 4 * i);
      req1 = (i == 1); addr1 = 6'd9;
      @(negedge clk);
      n_tests++;
      if (gnt0_w[2] !== (i != 1) || gnt1_w[2] !== (i == 1)) begin
        n_fail++;
        $display("FAIL b2b_grant step%0d: gnt0=%b gnt1=%b", i, gnt0_w[2], gnt1_w[2]);
      end
      next_cycle();
    end
    req0 = 0; req1 = 0;
    for (int j = 0; j < 3; j++) begin
      logic [DW-1:0] d;
      d = (j == 1) ? mem_word(6'd9) : mem_word(6'(7 + 4 * j));
      @(negedge clk);
      n_tests++;
      if (rvalid0_w[2] !== (j != 1) || rvalid1_w[2] !== (j == 1) ||
          ((j == 1) ? rdata1_w[2] : rdata0_w[2]) !== d) begin
        n_fail++;
        $display("FAIL b2b_return step%0d: rvalid0=%b rvalid1=%b rdata0=%h rdata1=%h, want data %h",
                 j, rvalid0_w[2], rvalid1_w[2], rdata0_w[2], rdata1_w[2], d);
      end
      next_cycle();
    end
    idle(3);
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    req0 = 1; addr0 = 6'd3;
    @(negedge clk);
    n_tests++;
    if (gnt0_w[1] !== 1) begin
      n_fail++;
      $display("FAIL midrst_grant: gnt0=%b, want 1", gnt0_w[1]);
    end
    next_cycle();
    req0 = 0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rvalid0_w[1] !== 0 || rvalid1_w[1] !== 0 || rdata0_w[1] !== '0 || busy_w[1] !== 0 ||
        mem_addr_w[1] !== '0 || gnt0_w[1] !== 0) begin
      n_fail++;
      $display("FAIL midrst_clear: rv0=%b rv1=%b rd0=%h busy=%b ma=%h gnt0=%b, want all 0",
               rvalid0_w[1], rvalid1_w[1], rdata0_w[1], busy_w[1], mem_addr_w[1], gnt0_w[1]);
    end
    next_cycle();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_tests++;
      if (rvalid0_w[1] !== 0) begin
        n_fail++;
        $display("FAIL midrst_no_return step%0d: rvalid0=%b, want 0", j, rvalid0_w[1]);
      end
      next_cycle();
    end
  endtask

  task automatic test_idle();
    reset_dut();
    req1 = 1; addr1 = 6'h2A;
    next_cycle();
    req1 = 0; addr1 = 6'h11; addr0 = 6'h22;
    repeat (13) next_cycle();
    @(negedge clk);
    for (int k = 0; k < NL; k++) begin
      n_tests++;
      if (busy_w[k] !== 0 || mem_addr_w[k] !== 6'h2A) begin
        n_fail++;
        $display("FAIL idle_state lane%0d: busy=%b mem_addr=%h, want 0 2a", k, busy_w[k], mem_addr_w[k]);
      end
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_lock();
    test_back_to_back();
    test_reset_midflight();
    test_idle();
    idle(4);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d reads never returned, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
